// File: rtl/cc_setpoint_sequencer_pkg.sv
// Shared encodings for the setpoint sequencer: FSM state codes and mode values.
package cc_setpoint_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/cc_setpoint_sequencer_vector_select.sv
// Combinational pick of one N_WIDTH entry from a packed bus; indices past the
// last entry are clamped to DEPTH-1.
module cc_vector_select #(
  parameter int N_WIDTH = 17,
  parameter int DEPTH   = 8,
  parameter int N_SEL   = 3
) (
  input  logic [DEPTH*N_WIDTH-1:0] i_bus,
  input  logic [N_SEL-1:0]         i_index,
  output logic [N_WIDTH-1:0]       o_value
);

  localparam logic [N_SEL-1:0] IDX_MAX = N_SEL'(DEPTH - 1);

  logic [N_SEL-1:0] w_idx;

  assign w_idx   = (int'(i_index) > DEPTH - 1) ? IDX_MAX : i_index;
  assign o_value = i_bus[w_idx*N_WIDTH +: N_WIDTH];

endmodule

// File: rtl/cc_setpoint_sequencer.sv
// Setpoint sequencer: manual select tracking or auto stepping through entries
// 0..last on advance pulses, with one registered (x,y,z) triplet on the outputs.
module cc_setpoint_sequencer
  import cc_setpoint_sequencer_pkg::*;
#(
  parameter int N_WIDTH = 17,
  parameter int DEPTH   = 8,
  parameter int N_SEL   = 3
) (
  input  logic                     CC_SETPOINT_SEQ_CLOCK_50,
  input  logic                     CC_SETPOINT_SEQ_RESET_InLow,
  input  logic [DEPTH*N_WIDTH-1:0] CC_SETPOINT_SEQ_x_InBus,
  input  logic [DEPTH*N_WIDTH-1:0] CC_SETPOINT_SEQ_y_InBus,
  input  logic [DEPTH*N_WIDTH-1:0] CC_SETPOINT_SEQ_z_InBus,
  input  logic                     CC_SETPOINT_SEQ_mode_In,
  input  logic [N_SEL-1:0]         CC_SETPOINT_SEQ_select_InBus,
  input  logic                     CC_SETPOINT_SEQ_start_In,
  input  logic                     CC_SETPOINT_SEQ_advance_In,
  input  logic                     CC_SETPOINT_SEQ_loop_In,
  input  logic [N_SEL-1:0]         CC_SETPOINT_SEQ_last_InBus,
  output logic [N_WIDTH-1:0]       CC_SETPOINT_SEQ_x_OutBus,
  output logic [N_WIDTH-1:0]       CC_SETPOINT_SEQ_y_OutBus,
  output logic [N_WIDTH-1:0]       CC_SETPOINT_SEQ_z_OutBus,
  output logic [N_SEL-1:0]         CC_SETPOINT_SEQ_index_OutBus,
  output logic                     CC_SETPOINT_SEQ_valid_Out,
  output logic                     CC_SETPOINT_SEQ_busy_Out,
  output logic                     CC_SETPOINT_SEQ_done_Out,
  output logic [1:0]               CC_SETPOINT_SEQ_state_OutBus
);

  localparam logic [N_SEL-1:0] IDX_MAX = N_SEL'(DEPTH - 1);

  logic [1:0]         r_state;
  logic [N_SEL-1:0]   r_index;
  logic [N_WIDTH-1:0] r_x;
  logic [N_WIDTH-1:0] r_y;
  logic [N_WIDTH-1:0] r_z;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic [N_SEL-1:0]   w_sel_c;
  logic [N_SEL-1:0]   w_last_c;
  logic [1:0]         w_state_nxt;
  logic [N_SEL-1:0]   w_idx_nxt;
  logic               w_load;
  logic               w_valid_nxt;
  logic [N_WIDTH-1:0] w_x_sel;
  logic [N_WIDTH-1:0] w_y_sel;
  logic [N_WIDTH-1:0] w_z_sel;

  assign w_sel_c  = (int'(CC_SETPOINT_SEQ_select_InBus) > DEPTH - 1) ? IDX_MAX
                                                                     : CC_SETPOINT_SEQ_select_InBus;
  assign w_last_c = (int'(CC_SETPOINT_SEQ_last_InBus) > DEPTH - 1) ? IDX_MAX
                                                                   : CC_SETPOINT_SEQ_last_InBus;

  // Manual mode wins from any state, so dropping mode acts as an abort.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_index;
    w_load      = 1'b0;
    w_valid_nxt = 1'b0;
    if (CC_SETPOINT_SEQ_mode_In == MODE_MANUAL) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = w_sel_c;
      w_load      = 1'b1;
      w_valid_nxt = (w_sel_c != r_index);
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (CC_SETPOINT_SEQ_start_In) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          if (CC_SETPOINT_SEQ_advance_In) begin
            // index >= last also covers last being lowered mid-sequence.
            if (r_index < w_last_c) begin
              w_idx_nxt   = r_index + 1'b1;
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
            end else if (CC_SETPOINT_SEQ_loop_In) begin
              w_idx_nxt   = '0;
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  cc_vector_select #(.N_WIDTH(N_WIDTH), .DEPTH(DEPTH), .N_SEL(N_SEL)) u_sel_x (
    .i_bus   (CC_SETPOINT_SEQ_x_InBus),
    .i_index (w_idx_nxt),
    .o_value (w_x_sel)
  );

  cc_vector_select #(.N_WIDTH(N_WIDTH), .DEPTH(DEPTH), .N_SEL(N_SEL)) u_sel_y (
    .i_bus   (CC_SETPOINT_SEQ_y_InBus),
    .i_index (w_idx_nxt),
    .o_value (w_y_sel)
  );

  cc_vector_select #(.N_WIDTH(N_WIDTH), .DEPTH(DEPTH), .N_SEL(N_SEL)) u_sel_z (
    .i_bus   (CC_SETPOINT_SEQ_z_InBus),
    .i_index (w_idx_nxt),
    .o_value (w_z_sel)
  );

  always_ff @(posedge CC_SETPOINT_SEQ_CLOCK_50 or negedge CC_SETPOINT_SEQ_RESET_InLow) begin
    if (!CC_SETPOINT_SEQ_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_index <= w_idx_nxt;
        r_x     <= w_x_sel;
        r_y     <= w_y_sel;
        r_z     <= w_z_sel;
      end
    end
  end

  assign CC_SETPOINT_SEQ_x_OutBus     = r_x;
  assign CC_SETPOINT_SEQ_y_OutBus     = r_y;
  assign CC_SETPOINT_SEQ_z_OutBus     = r_z;
  assign CC_SETPOINT_SEQ_index_OutBus = r_index;
  assign CC_SETPOINT_SEQ_valid_Out    = r_valid;
  assign CC_SETPOINT_SEQ_busy_Out     = r_busy;
  assign CC_SETPOINT_SEQ_done_Out     = r_done;
  assign CC_SETPOINT_SEQ_state_OutBus = r_state;

endmodule
